pump_sequencer: RTL and testbench
=================================

Name: pump_sequencer

Overview:
Sequences the filtration actuators between the tactical control FSM and the PWM generators.
- Applies a motor lead time before any pump starts.
- Slews pump duty in steps (soft start/stop).
- Inserts a dead time when pumping changes between pump A (filling) and pump B (returning). Both pumps are never driven at once.
- Outputs are 8-bit duty words that feed the pwm_generator instances directly.

Parameters:
MOTOR_LEAD, 100000, clock cycles motors run before any pump is enabled (>=1)
RAMP_DIV, 1000, clock cycles per 1-LSB pump duty step (>=1)
DEAD_CYCLES, 50000, clock cycles both pumps are held at 0 between pump changes (>=1)
WATCHDOG_CYCLES, 50000000, max cycles in RUN before fault (used only with the optional feature)

Ports:
clk_fpga  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
i_run  in  1  level; 1 = filtration requested
i_sel_b  in  1  pump select; 0 = pump A, 1 = pump B
i_duty  in  8  target pump duty
o_duty_motor  out  8  motor duty word (8'h00 or 8'hFF)
o_duty_bomba_a  out  8  pump A duty word
o_duty_bomba_b  out  8  pump B duty word
o_busy  out  1  1 whenever state != IDLE
o_fault  out  1  sticky watchdog fault

Behaviour:
- One clock, clk_fpga. reset is synchronous and active-high.
- Reset, including mid-operation, takes effect at the next edge. It sets:
  - state = IDLE
  - cur_duty = 0, active_sel = 0
  - all counters = 0
  - all outputs = 0, including o_fault
- All outputs are registered. They reflect state and cur_duty with 1-cycle latency.
- States are IDLE, LEAD, RUN, RAMP_DOWN, DEAD, FAULT. FAULT exists only with the macro.
- IDLE:
  - Motor 0, pumps 0.
  - i_run=1 → LEAD; lead counter cleared.
- LEAD:
  - Motor 8'hFF, pumps 0.
  - i_run=0 → IDLE immediately.
  - After MOTOR_LEAD cycles in LEAD: latch active_sel = i_sel_b, clear prescaler, → RUN.
- RUN: cur_duty slews toward i_duty by ±1 at each prescaler tick.
  - The prescaler counts 0..RAMP_DIV-1; a tick occurs at RAMP_DIV-1, then the count wraps to 0.
  - cur_duty holds when equal to i_duty.
  - i_duty is sampled at each tick, so a target change mid-ramp takes effect at the next tick. No overshoot, no wrap: 8-bit saturating at 0 and 255.
  - i_duty=0 slews to 0 and remains in RUN.
  - i_run=0 or i_sel_b != active_sel → RAMP_DOWN. The prescaler keeps running.
- RAMP_DOWN:
  - cur_duty decrements by 1 per tick.
  - At cur_duty==0 (including on entry at 0) → DEAD; dead counter cleared.
  - Changes of i_run/i_sel_b are ignored here.
- DEAD:
  - Motor 8'hFF, pumps 0, for DEAD_CYCLES cycles.
  - Then: i_run=1 → latch active_sel = i_sel_b, → RUN; else → IDLE.
- Pump mapping:
  - o_duty_bomba_a = cur_duty when active_sel=0, else 0.
  - o_duty_bomba_b = cur_duty when active_sel=1, else 0.
  - Invariant: never both nonzero in the same cycle.
- o_duty_motor = 8'hFF in LEAD, RUN, RAMP_DOWN, DEAD; 8'h00 in IDLE and FAULT.
- Simultaneous i_run=0 and sel change in RUN: a single RAMP_DOWN, then IDLE.

Optional Feature:
Macro PUMP_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs while in RUN and clears on leaving RUN.
  - Reaching WATCHDOG_CYCLES → FAULT.
  - FAULT: all duty outputs 0, o_fault=1, o_busy=1. It is exited only by reset; inputs are ignored.
- Undefined:
  - No FAULT state and no counter.
  - o_fault tied 0; WATCHDOG_CYCLES unused.

Test Plan:
Bench parameters: MOTOR_LEAD=3, RAMP_DIV=2, DEAD_CYCLES=4, WATCHDOG_CYCLES=40.
1. Reset, then i_run=1, i_sel_b=0, i_duty=4 → motor 8'hFF one cycle later; bomba_a=0 for the lead; bomba_a then steps 1,2,3,4 every 2 cycles and holds 4; bomba_b=0 throughout.
2. Steady at A=4, set i_sel_b=1 → A ramps 4→0 over 8 cycles; both pumps 0 for 4 cycles; B ramps to 4; motor stays FF; assert the both-nonzero invariant every cycle.
3. In RUN at duty 4, drop i_run → ramp to 0, dead 4 cycles, IDLE; motor 0; o_busy falls.
4. i_run pulsed high for 2 cycles (shorter than the lead) → LEAD then IDLE; pump outputs never leave 0.
5. Assert reset while bomba_a=2 mid-ramp → all outputs 0 at the next edge; state IDLE.
6. PUMP_SEQ_WATCHDOG_EN defined, hold RUN for 40 cycles → o_fault=1, all duties 0, sticky across i_run toggles until reset. Macro undefined, same stimulus → o_fault stays 0.

Source files
------------

// File: rtl/pump_sequencer.sv
// Filtration actuator sequencer: motor lead, soft-start/stop pump slewing, pump-change dead time.
// Optional watchdog fault in RUN is enabled by defining PUMP_SEQ_WATCHDOG_EN.
module pump_sequencer #(
  parameter int unsigned MOTOR_LEAD      = 100000,
  parameter int unsigned RAMP_DIV        = 1000,
  parameter int unsigned DEAD_CYCLES     = 50000,
  parameter int unsigned WATCHDOG_CYCLES = 50000000
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_sel_b,
  input  logic [7:0] i_duty,
  output logic [7:0] o_duty_motor,
  output logic [7:0] o_duty_bomba_a,
  output logic [7:0] o_duty_bomba_b,
  output logic       o_busy,
  output logic       o_fault
);

  localparam int unsigned LW = (MOTOR_LEAD > 1) ? $clog2(MOTOR_LEAD) : 1;
  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [LW-1:0] LEAD_LAST  = LW'(MOTOR_LEAD - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_RUN,
    ST_RAMP_DOWN,
    ST_DEAD
`ifdef PUMP_SEQ_WATCHDOG_EN
    ,
    ST_FAULT
`endif
  } state_t;

  state_t        state_q;
  logic [7:0]    cur_duty_q;
  logic          active_sel_q;
  logic [LW-1:0] lead_cnt_q;
  logic [PW-1:0] presc_q;
  logic [DW-1:0] dead_cnt_q;
  logic [7:0]    motor_q;
  logic [7:0]    bomba_a_q;
  logic [7:0]    bomba_b_q;
  logic          busy_q;

  logic          tick;
  logic [PW-1:0] presc_d;
  logic          pump_req_off;
  logic          lead_done;
  logic          dead_done;
  logic          motor_on;

  // One LSB toward the target; the compare keeps it from overshooting or wrapping.
  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

  function automatic logic [7:0] step_down_sat(input logic [7:0] cur);
    return (cur == 8'h00) ? 8'h00 : cur - 8'd1;
  endfunction

  always_comb begin
    tick         = (presc_q == PRESC_LAST);
    presc_d      = tick ? '0 : presc_q + 1'b1;
    pump_req_off = !i_run || (i_sel_b != active_sel_q);
    lead_done    = (lead_cnt_q == LEAD_LAST);
    dead_done    = (dead_cnt_q == DEAD_LAST);
    motor_on     = (state_q == ST_LEAD) || (state_q == ST_RUN) ||
                   (state_q == ST_RAMP_DOWN) || (state_q == ST_DEAD);
  end

`ifdef PUMP_SEQ_WATCHDOG_EN
  localparam int unsigned WW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);

  logic [WW-1:0] wd_cnt_q;
  logic          fault_q;
  logic          wd_expired;

  assign wd_expired = (wd_cnt_q == WD_LAST);
  assign o_fault    = fault_q;
`else
  logic unused_wd_param;

  assign unused_wd_param = ^WATCHDOG_CYCLES;
  assign o_fault         = 1'b0;
`endif

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_duty_q   <= 8'h00;
      active_sel_q <= 1'b0;
      lead_cnt_q   <= '0;
      presc_q      <= '0;
      dead_cnt_q   <= '0;
      motor_q      <= 8'h00;
      bomba_a_q    <= 8'h00;
      bomba_b_q    <= 8'h00;
      busy_q       <= 1'b0;
`ifdef PUMP_SEQ_WATCHDOG_EN
      wd_cnt_q     <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      // Outputs follow the current state and duty, so they trail transitions by one cycle.
      motor_q   <= motor_on ? 8'hFF : 8'h00;
      bomba_a_q <= active_sel_q ? 8'h00 : cur_duty_q;
      bomba_b_q <= active_sel_q ? cur_duty_q : 8'h00;
      busy_q    <= (state_q != ST_IDLE);

      case (state_q)
        ST_IDLE: begin
          if (i_run) begin
            state_q    <= ST_LEAD;
            lead_cnt_q <= '0;
          end
        end
        ST_LEAD: begin
          if (!i_run) begin
            state_q <= ST_IDLE;
          end else if (lead_done) begin
            state_q      <= ST_RUN;
            active_sel_q <= i_sel_b;
            presc_q      <= '0;
          end else begin
            lead_cnt_q <= lead_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          presc_q <= presc_d;
          if (pump_req_off) begin
            state_q <= ST_RAMP_DOWN;
          end else if (tick) begin
            cur_duty_q <= slew_toward(cur_duty_q, i_duty);
          end
        end
        ST_RAMP_DOWN: begin
          presc_q <= presc_d;
          if (cur_duty_q == 8'h00) begin
            state_q    <= ST_DEAD;
            dead_cnt_q <= '0;
          end else if (tick) begin
            cur_duty_q <= step_down_sat(cur_duty_q);
          end
        end
        ST_DEAD: begin
          if (dead_done) begin
            if (i_run) begin
              state_q      <= ST_RUN;
              active_sel_q <= i_sel_b;
              presc_q      <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            dead_cnt_q <= dead_cnt_q + 1'b1;
          end
        end
`ifdef PUMP_SEQ_WATCHDOG_EN
        ST_FAULT: begin
          cur_duty_q <= 8'h00;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

`ifdef PUMP_SEQ_WATCHDOG_EN
      // Watchdog overrides any RUN transition decided above.
      if (state_q == ST_RUN) begin
        if (wd_expired) begin
          state_q    <= ST_FAULT;
          cur_duty_q <= 8'h00;
        end else begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
      end else begin
        wd_cnt_q <= '0;
      end
      fault_q <= (state_q == ST_FAULT);
`endif
    end
  end

  assign o_duty_motor   = motor_q;
  assign o_duty_bomba_a = bomba_a_q;
  assign o_duty_bomba_b = bomba_b_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Scoreboard bench for pump_sequencer; a phase/countdown reference model queues expected outputs.
`timescale 1ns/1ps
module tb_pump_sequencer;

  localparam int MOTOR_LEAD      = 3;
  localparam int RAMP_DIV        = 2;
  localparam int DEAD_CYCLES     = 4;
  localparam int WATCHDOG_CYCLES = 40;

  logic       clk_fpga = 1'b0;
  logic       reset    = 1'b1;
  logic       i_run    = 1'b0;
  logic       i_sel_b  = 1'b0;
  logic [7:0] i_duty   = 8'h00;
  logic [7:0] o_duty_motor, o_duty_bomba_a, o_duty_bomba_b;
  logic       o_busy, o_fault;

  pump_sequencer #(
    .MOTOR_LEAD(MOTOR_LEAD),
    .RAMP_DIV(RAMP_DIV),
    .DEAD_CYCLES(DEAD_CYCLES),
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) dut (
    .clk_fpga(clk_fpga),
    .reset(reset),
    .i_run(i_run),
    .i_sel_b(i_sel_b),
    .i_duty(i_duty),
    .o_duty_motor(o_duty_motor),
    .o_duty_bomba_a(o_duty_bomba_a),
    .o_duty_bomba_b(o_duty_bomba_b),
    .o_busy(o_busy),
    .o_fault(o_fault)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct packed {
    logic [7:0] motor;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       fault;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: what the filtration system is doing, tracked with countdowns.
  typedef enum int {M_OFF, M_SPINUP, M_PUMPING, M_WINDDOWN, M_GAP, M_TRIPPED} mphase_t;
  mphase_t m_phase     = M_OFF;
  int      m_duty      = 0;
  bit      m_sel       = 1'b0;
  int      m_lead_left = 0;
  int      m_dead_left = 0;
  int      m_ticks     = 0;
  int      m_run_time  = 0;

  task automatic model_edge(input bit rst, input bit run, input bit sel, input logic [7:0] tgt);
    obs_t e;
    bit   tick;
    if (rst) begin
      e = '0;
    end else begin
      e.motor = (m_phase == M_OFF || m_phase == M_TRIPPED) ? 8'h00 : 8'hFF;
      e.a     = m_sel ? 8'h00 : 8'(m_duty);
      e.b     = m_sel ? 8'(m_duty) : 8'h00;
      e.busy  = (m_phase != M_OFF);
      e.fault = (m_phase == M_TRIPPED);
    end
    exp_q.push_back(e);

    if (rst) begin
      m_phase = M_OFF; m_duty = 0; m_sel = 1'b0;
      m_lead_left = 0; m_dead_left = 0; m_ticks = 0; m_run_time = 0;
      return;
    end
    tick = ((m_ticks % RAMP_DIV) == RAMP_DIV - 1);
    case (m_phase)
      M_OFF: if (run) begin m_phase = M_SPINUP; m_lead_left = MOTOR_LEAD; end
      M_SPINUP: begin
        if (!run) m_phase = M_OFF;
        else begin
          m_lead_left--;
          if (m_lead_left == 0) begin
            m_phase = M_PUMPING; m_sel = sel; m_ticks = 0; m_run_time = 0;
          end
        end
      end
      M_PUMPING: begin
        m_ticks++;
        m_run_time++;
`ifdef PUMP_SEQ_WATCHDOG_EN
        if (m_run_time == WATCHDOG_CYCLES) begin
          m_phase = M_TRIPPED; m_duty = 0;
        end else
`endif
        if (!run || sel != m_sel) m_phase = M_WINDDOWN;
        else if (tick && m_duty < int'(tgt)) m_duty++;
        else if (tick && m_duty > int'(tgt)) m_duty--;
      end
      M_WINDDOWN: begin
        m_ticks++;
        if (m_duty == 0) begin m_phase = M_GAP; m_dead_left = DEAD_CYCLES; end
        else if (tick) m_duty--;
      end
      M_GAP: begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          if (run) begin
            m_phase = M_PUMPING; m_sel = sel; m_ticks = 0; m_run_time = 0;
          end else m_phase = M_OFF;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit rst, input bit run, input bit sel, input logic [7:0] duty);
    @(negedge clk_fpga);
    reset = rst; i_run = run; i_sel_b = sel; i_duty = duty;
    model_edge(rst, run, sel, duty);
  endtask

  task automatic settle();
    @(posedge clk_fpga);
    #2;
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: every clock the DUT presents a full output word; pop and compare.
  initial begin
    obs_t e, o;
    forever begin
      @(posedge clk_fpga);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = '{o_duty_motor, o_duty_bomba_a, o_duty_bomba_b, o_busy, o_fault};
        compared++;
        if (o !== e) begin
          mismatched++;
          $display("FAIL outputs @%0t: got motor=%h a=%h b=%h busy=%b fault=%b, required motor=%h a=%h b=%h busy=%b fault=%b",
                   $time, o.motor, o.a, o.b, o.busy, o.fault, e.motor, e.a, e.b, e.busy, e.fault);
        end
        compared++;
        if (o_duty_bomba_a != 8'h00 && o_duty_bomba_b != 8'h00) begin
          mismatched++;
          $display("FAIL both_pumps @%0t: got a=%h b=%h, required one of them 00",
                   $time, o_duty_bomba_a, o_duty_bomba_b);
        end
      end
    end
  end

  initial begin
    bit         r, sl, rr;
    logic [7:0] d;
    int         len, guard;

    // Reset state
    step(1, 0, 0, 8'd0);
    step(1, 0, 0, 8'd0);
    settle();
    check_val("reset_motor", o_duty_motor, 8'h00);
    check_val("reset_a", o_duty_bomba_a, 8'h00);
    check_val("reset_busy", {7'd0, o_busy}, 8'h00);
    check_val("reset_fault", {7'd0, o_fault}, 8'h00);

    // Soft start on pump A
    for (int k = 0; k < 20; k++) step(0, 1, 0, 8'd4);
    settle();
    check_val("startA_a", o_duty_bomba_a, 8'd4);
    check_val("startA_b", o_duty_bomba_b, 8'd0);
    check_val("startA_motor", o_duty_motor, 8'hFF);

    // Pump change A -> B
    for (int k = 0; k < 30; k++) step(0, 1, 1, 8'd4);
    settle();
    check_val("swapB_b", o_duty_bomba_b, 8'd4);
    check_val("swapB_a", o_duty_bomba_a, 8'd0);

    // Stop: ramp down, dead time, idle
    for (int k = 0; k < 20; k++) step(0, 0, 1, 8'd4);
    settle();
    check_val("stop_motor", o_duty_motor, 8'h00);
    check_val("stop_busy", {7'd0, o_busy}, 8'h00);

    // Run pulse shorter than the motor lead
    step(1, 0, 0, 8'd0);
    step(0, 1, 0, 8'd9);
    step(0, 1, 0, 8'd9);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 8'd9);
    settle();
    check_val("pulse_busy", {7'd0, o_busy}, 8'h00);

    // Reset in the middle of a ramp
    step(1, 0, 0, 8'd0);
    guard = 0;
    while (m_duty != 2 && guard < 40) begin
      step(0, 1, 0, 8'd4);
      guard++;
    end
    compared++;
    if (guard >= 40) begin
      mismatched++;
      $display("FAIL midramp_reach: got duty %0d after %0d cycles, required 2", m_duty, guard);
    end
    step(0, 1, 0, 8'd4);
    step(1, 1, 0, 8'd4);
    settle();
    check_val("midreset_a", o_duty_bomba_a, 8'd0);
    check_val("midreset_motor", o_duty_motor, 8'h00);

    // Randomized segments; target changes mid-ramp, selections, stops and resets
    for (int s = 0; s < 70; s++) begin
      r   = ($urandom_range(0, 3) != 0);
      sl  = ($urandom_range(0, 1) == 1);
      rr  = ($urandom_range(0, 9) == 0);
      d   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      len = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) step(rr && k == 0, r, sl, d);
    end

    // Long continuous RUN (watchdog window)
    step(1, 0, 0, 8'd0);
    for (int k = 0; k < 50; k++) step(0, 1, 0, 8'd10);
    settle();
`ifdef PUMP_SEQ_WATCHDOG_EN
    check_val("wd_fault", {7'd0, o_fault}, 8'h01);
    check_val("wd_a", o_duty_bomba_a, 8'h00);
    check_val("wd_motor", o_duty_motor, 8'h00);
    for (int k = 0; k < 6; k++) step(0, (k % 2) == 0, 1, 8'd10);
    settle();
    check_val("wd_sticky", {7'd0, o_fault}, 8'h01);
    check_val("wd_busy", {7'd0, o_busy}, 8'h01);
`else
    check_val("nowd_fault", {7'd0, o_fault}, 8'h00);
    check_val("nowd_a", o_duty_bomba_a, 8'd10);
    for (int k = 0; k < 6; k++) step(0, (k % 2) == 0, 1, 8'd10);
    settle();
    check_val("nowd_fault2", {7'd0, o_fault}, 8'h00);
`endif
    step(1, 0, 0, 8'd0);
    settle();
    check_val("final_fault", {7'd0, o_fault}, 8'h00);

    repeat (2) @(posedge clk_fpga);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
